// File: rtl/elevator_ctrl_nfloor_pkg.sv
// rtl/elevator_ctrl_nfloor_pkg.sv - shared elevator state encoding and sizing helpers
// Contents: state_t (IDLE/MOVING/DOOR_OPEN), floor_w() floor-index width, max_int().
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVING    = 2'd1,
        DOOR_OPEN = 2'd2
    } state_t;

    // Floor index width; a 1-floor degenerate build still needs one bit.
    function automatic int floor_w(input int num_floors);
        return (num_floors > 1) ? $clog2(num_floors) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/elevator_ctrl_nfloor_if.sv
// rtl/elevator_ctrl_nfloor_if.sv - call/door inputs and car status outputs of the elevator controller
// master: drives call_req, door_hold; observes current_floor, pending, move_up, move_down, door_open, dir_up, idle.
// slave : the controller side of the same signals.
interface elevator_ctrl_nfloor_if
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8
);
    localparam int FLOOR_W = floor_w(NUM_FLOORS);

    logic [NUM_FLOORS-1:0] call_req;
    logic                  door_hold;
    logic [FLOOR_W-1:0]    current_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  move_up;
    logic                  move_down;
    logic                  door_open;
    logic                  dir_up;
    logic                  idle;

    modport master (
        output call_req, door_hold,
        input  current_floor, pending, move_up, move_down, door_open, dir_up, idle
    );

    modport slave (
        input  call_req, door_hold,
        output current_floor, pending, move_up, move_down, door_open, dir_up, idle
    );

endinterface

// File: rtl/elevator_ctrl_nfloor_timer.sv
// rtl/elevator_ctrl_nfloor_timer.sv - loadable down-counter shared by door and travel phases
// Ports: clk, rst (sync, active-high), load, load_val[W], zero (count is 0).
module elev_cycle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Saturates at zero so an idle car keeps a stable zero flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/elevator_ctrl_nfloor.sv
// rtl/elevator_ctrl_nfloor.sv - N-floor SCAN elevator controller with timed door and travel phases
// Ports: clk, rst (sync, active-high), bus (slave): call_req, door_hold in;
//        current_floor, pending, move_up, move_down, door_open, dir_up, idle out.
module elevator_ctrl_nfloor
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 8,
    parameter int DOOR_CYCLES   = 4,
    parameter int TRAVEL_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    elevator_ctrl_nfloor_if.slave  bus
);

    localparam int FLOOR_W = floor_w(NUM_FLOORS);
    localparam int TMR_MAX = max_int(DOOR_CYCLES, TRAVEL_CYCLES) - 1;
    localparam int TMR_W   = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;
    localparam logic [TMR_W-1:0] DOOR_LOAD   = TMR_W'(DOOR_CYCLES - 1);
    localparam logic [TMR_W-1:0] TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES - 1);

    state_t                state, state_nxt;
    logic [FLOOR_W-1:0]    floor_q, floor_nxt, eval_floor, stepped_floor;
    logic [NUM_FLOORS-1:0] pending_q, pending_nxt, req, clr;
    logic [NUM_FLOORS-1:0] above_vec, below_vec, floor_hot;
    logic                  dir_q, dir_nxt;
    logic                  above, below, here, call_here;
    logic                  hop_done, door_reload, tmr_zero, tmr_load;
    logic [TMR_W-1:0]      tmr_load_val;

    elev_cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .zero     (tmr_zero)
    );

    assign req           = pending_q | bus.call_req;
    assign hop_done      = (state == MOVING) && tmr_zero;
    assign stepped_floor = dir_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));
    // On the edge that finishes a hop the decision is taken at the floor being
    // arrived at, so a requested floor always stops the car.
    assign eval_floor    = hop_done ? stepped_floor : floor_q;

    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor_terms
        assign floor_hot[i] = (FLOOR_W'(i) == eval_floor);
        assign above_vec[i] = req[i] && (FLOOR_W'(i) > eval_floor);
        assign below_vec[i] = req[i] && (FLOOR_W'(i) < eval_floor);
    end

    assign above       = |above_vec;
    assign below       = |below_vec;
    assign here        = |(req & floor_hot);
    assign call_here   = |(bus.call_req & floor_hot);
    assign door_reload = bus.door_hold || call_here;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            floor_q   <= '0;
            pending_q <= '0;
            dir_q     <= 1'b1;
        end else begin
            state     <= state_nxt;
            floor_q   <= floor_nxt;
            pending_q <= pending_nxt;
            dir_q     <= dir_nxt;
        end
    end

    always_comb begin
        logic decide;
        logic use_here;
        logic go_fwd;
        logic go_rev;

        state_nxt    = state;
        floor_nxt    = floor_q;
        dir_nxt      = dir_q;
        decide       = 1'b0;
        use_here     = 1'b1;
        go_fwd       = dir_q ? above : below;
        go_rev       = dir_q ? below : above;
        tmr_load     = 1'b0;
        tmr_load_val = TRAVEL_LOAD;

        case (state)
            IDLE: begin
                decide = 1'b1;
            end
            MOVING: begin
                if (tmr_zero) begin
                    floor_nxt = eval_floor;
                    decide    = 1'b1;
                end
            end
            DOOR_OPEN: begin
                // The floor was cleared on entry, so expiry only looks away.
                if (tmr_zero && !door_reload) begin
                    decide   = 1'b1;
                    use_here = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (decide) begin
            if (use_here && here) begin
                state_nxt = DOOR_OPEN;
            end else if (go_fwd) begin
                state_nxt = MOVING;
            end else if (go_rev) begin
                state_nxt = MOVING;
                dir_nxt   = !dir_q;
            end else begin
                state_nxt = IDLE;
            end
        end

        if (state_nxt == MOVING && (state != MOVING || hop_done)) begin
            tmr_load     = 1'b1;
            tmr_load_val = TRAVEL_LOAD;
        end else if (state_nxt == DOOR_OPEN && (state != DOOR_OPEN || door_reload)) begin
            tmr_load     = 1'b1;
            tmr_load_val = DOOR_LOAD;
        end

        // A call for the floor whose door is open is absorbed here.
        clr         = (state_nxt == DOOR_OPEN) ? floor_hot : '0;
        pending_nxt = req & ~clr;
    end

    always_comb begin
        bus.move_up   = (state == MOVING) && dir_q;
        bus.move_down = (state == MOVING) && !dir_q;
        bus.door_open = (state == DOOR_OPEN);
        bus.idle      = (state == IDLE);
    end

    assign bus.current_floor = floor_q;
    assign bus.pending       = pending_q;
    assign bus.dir_up        = dir_q;

endmodule

// File: tb/tb_elevator_ctrl_nfloor.sv
// tb/tb_elevator_ctrl_nfloor.sv - directed self-checking bench for elevator_ctrl_nfloor
module tb_elevator_ctrl_nfloor;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    elevator_ctrl_nfloor_if #(.NUM_FLOORS(8)) bus ();

    elevator_ctrl_nfloor #(
        .NUM_FLOORS    (8),
        .DOOR_CYCLES   (4),
        .TRAVEL_CYCLES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // sel 0: wait for door_open, sel 1: wait for idle
    task automatic wait_for(input int sel, input int limit, input string tag);
        int n;
        n = 0;
        while (((sel == 0) ? bus.door_open : bus.idle) !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        chk(tag, (sel == 0) ? bus.door_open : bus.idle, 1);
    endtask

    task automatic pulse(input logic [7:0] calls);
        bus.call_req = calls;
        step();
        bus.call_req = 8'h00;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.call_req  = 8'hFF;
        bus.door_hold = 1'b0;

        // 1. reset with every call asserted
        step();
        step();
        chk("rst_floor", bus.current_floor, 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_idle", bus.idle, 1);
        chk("rst_dir_up", bus.dir_up, 1);
        chk("rst_moves", {bus.move_up, bus.move_down, bus.door_open}, 0);
        rst          = 1'b0;
        bus.call_req = 8'h00;
        step();
        chk("post_rst_idle", bus.idle, 1);

        // 2. single trip 0 -> 3
        pulse(8'h08);
        chk("trip_pending", bus.pending, 32'h08);
        for (int i = 0; i < 9; i++) begin
            chk("trip_move_up", bus.move_up, 1);
            chk("trip_floor", bus.current_floor, i / 3);
            chk("trip_no_door", bus.door_open, 0);
            step();
        end
        for (int j = 0; j < 4; j++) begin
            chk("trip_door", bus.door_open, 1);
            chk("trip_door_floor", bus.current_floor, 3);
            chk("trip_door_still", {bus.move_up, bus.move_down}, 0);
            step();
        end
        chk("trip_idle", bus.idle, 1);
        chk("trip_cleared", bus.pending, 0);

        // 3. SCAN order: heading for 6, calls for 5 and 1 arrive mid-hop
        pulse(8'h40);
        pulse(8'h22);
        chk("scan_pending", bus.pending, 32'h62);
        chk("scan_move_up", bus.move_up, 1);
        wait_for(0, 30, "scan_wait_5");
        chk("scan_stop_5", bus.current_floor, 5);
        chk("scan_dir_5", bus.dir_up, 1);
        chk("scan_pend_5", bus.pending, 32'h42);
        repeat (4) step();
        wait_for(0, 30, "scan_wait_6");
        chk("scan_stop_6", bus.current_floor, 6);
        repeat (4) step();
        chk("scan_reverse", bus.move_down, 1);
        chk("scan_dir_dn", bus.dir_up, 0);
        wait_for(0, 40, "scan_wait_1");
        chk("scan_stop_1", bus.current_floor, 1);
        wait_for(1, 10, "scan_idle");
        chk("scan_cleared", bus.pending, 0);

        // 4. door extension at floor 2
        pulse(8'h04);
        wait_for(0, 20, "hold_wait_2");
        chk("hold_floor", bus.current_floor, 2);
        bus.door_hold = 1'b1;
        repeat (5) step();
        chk("hold_open", bus.door_open, 1);
        bus.door_hold = 1'b0;
        pulse(8'h04);
        for (int k = 0; k < 4; k++) begin
            chk("ext_door", bus.door_open, 1);
            chk("ext_absorbed", bus.pending, 0);
            step();
        end
        chk("ext_idle", bus.idle, 1);

        // 5. direction tie from floor 4 heading down
        pulse(8'h20);
        wait_for(0, 20, "tie_wait_5");
        wait_for(1, 10, "tie_idle_5");
        pulse(8'h10);
        chk("tie_down_to_4", bus.move_down, 1);
        wait_for(0, 20, "tie_wait_4");
        chk("tie_floor_4", bus.current_floor, 4);
        wait_for(1, 10, "tie_idle_4");
        chk("tie_dir_dn", bus.dir_up, 0);
        pulse(8'h42);
        chk("tie_down_first", bus.move_down, 1);
        wait_for(0, 30, "tie_wait_1");
        chk("tie_stop_1", bus.current_floor, 1);
        repeat (4) step();
        chk("tie_then_up", bus.move_up, 1);
        chk("tie_dir_up", bus.dir_up, 1);
        wait_for(0, 40, "tie_wait_6");
        chk("tie_stop_6", bus.current_floor, 6);
        wait_for(1, 10, "tie_idle_6");

        // 6. reset during the 5 -> 6 hop
        pulse(8'h20);
        wait_for(0, 20, "mid_wait_5");
        wait_for(1, 10, "mid_idle_5");
        pulse(8'h80);
        chk("mid_moving", bus.move_up, 1);
        chk("mid_floor", bus.current_floor, 5);
        chk("mid_pending", bus.pending, 32'h80);
        rst          = 1'b1;
        bus.call_req = 8'h01;
        step();
        chk("mid_rst_floor", bus.current_floor, 0);
        chk("mid_rst_pending", bus.pending, 0);
        chk("mid_rst_idle", bus.idle, 1);
        chk("mid_rst_still", {bus.move_up, bus.move_down, bus.door_open}, 0);
        rst          = 1'b0;
        bus.call_req = 8'h00;
        step();
        chk("mid_after_idle", bus.idle, 1);
        chk("mid_after_pending", bus.pending, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl_nfloor.md
# elevator_ctrl_nfloor

Parametrised successor of the five-floor elevator controller. Serves `NUM_FLOORS` floors using latched call requests and SCAN (direction-preserving) scheduling. Adds a timed door-open phase and a timed one-floor-per-hop travel phase. Sits between the call-button/debounce logic and the motor/door drivers; all outputs are Moore-decoded from registered state.

## Interface

- `NUM_FLOORS`, 8: number of floors, ≥2; floor 0 is ground.
- `DOOR_CYCLES`, 4: cycles the door stays open per stop, ≥1.
- `TRAVEL_CYCLES`, 3: cycles to travel one floor, ≥1.
- `FLOOR_W` (localparam), `$clog2(NUM_FLOORS)`: floor index width.

- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `call_req` in NUM_FLOORS: one bit per floor; a one-cycle pulse is enough (latched internally).
- `door_hold` in 1: while high in DOOR_OPEN, reloads the door timer.
- `current_floor` out FLOOR_W: present floor index.
- `pending` out NUM_FLOORS: latched unserved requests.
- `move_up` out 1: high for every cycle of upward travel.
- `move_down` out 1: high for every cycle of downward travel.
- `door_open` out 1: high for every DOOR_OPEN cycle.
- `dir_up` out 1: SCAN direction register; 1 = up.
- `idle` out 1: high in IDLE.

## Operation

- States: IDLE, MOVING, DOOR_OPEN. Registers: `state`, `current_floor`, `pending`, `dir_up`, shared down-counter `tmr`.
- Effective requests: `req = pending | call_req`. Derived terms:
  - `above` = any `req` bit > `current_floor`.
  - `below` = any `req` bit < `current_floor`.
  - `here` = `req[current_floor]`.
- Latching: `pending <= (pending | call_req) & ~clr`. `clr` is the one-hot of `current_floor` on any edge that enters DOOR_OPEN or stays in it.
- A call for the current floor during DOOR_OPEN is absorbed, never latched, and reloads `tmr` to DOOR_CYCLES-1.
- Direction decision, used on exit from IDLE, on arrival, and on door expiry:
  - If `here`: go to DOOR_OPEN.
  - Else if there are requests in the `dir_up` direction: MOVING, same direction.
  - Else if there are requests in the opposite direction: MOVING, and toggle `dir_up`.
  - Else: IDLE, `dir_up` unchanged.
  - Door expiry skips the `here` check, because the floor was just cleared.
- IDLE: evaluate the decision every cycle.
- MOVING: `tmr` loads TRAVEL_CYCLES-1 on entry and decrements each cycle. At `tmr==0`, step `current_floor` by ±1 per `dir_up`, then apply the decision at the new floor, so a served floor always stops the car.
- DOOR_OPEN: `tmr` loads DOOR_CYCLES-1 on entry. `door_hold` or a same-floor call reloads it. At `tmr==0` with no reload, apply the decision.
- Floor limits: the car never steps below 0 or above NUM_FLOORS-1. This holds by construction, since `above` is 0 at the top floor and `below` is 0 at ground.
- Output decode:
  - `move_up = (state==MOVING) & dir_up`
  - `move_down = (state==MOVING) & ~dir_up`
  - `door_open = (state==DOOR_OPEN)`
  - `idle = (state==IDLE)`
- Reset values: state IDLE, `current_floor` 0, `pending` 0, `dir_up` 1, `tmr` 0. Resulting outputs: `move_up`/`move_down`/`door_open` 0, `idle` 1.
- Reset mid-operation: the car returns to the logical floor 0 with all requests dropped, including a `call_req` in the reset cycle.

## Timing

- A call seen at edge t, to a floor other than the current one, with the car IDLE: `move_*` goes high at t+1.
- A call for the current floor while IDLE: `door_open` goes high at t+1 for exactly DOOR_CYCLES cycles, absent holds.
- Each floor hop takes exactly TRAVEL_CYCLES cycles. `current_floor` changes on the same edge that leaves the hop.
- A k-floor trip with no intermediate stops takes k·TRAVEL_CYCLES cycles of `move_*`, then DOOR_CYCLES cycles of `door_open`.
- `pending` reflects a `call_req` one edge later, except for the absorbed same-floor case.
- `door_open` and `move_*` are never high together. There are no gap cycles between consecutive hops, or between a hop and its door phase.

## Structure

- Shared package `elevator_pkg`: state encoding constants (IDLE=2'd0, MOVING=2'd1, DOOR_OPEN=2'd2) and the `FLOOR_W` computation helper. Future elevator blocks reuse it.
- One sub-module, `elev_cycle_timer`: a loadable down-counter with `load`, `load_val`, and `zero` outputs. It is shared by door and travel, because those states are mutually exclusive.
- `above`/`below` are generate-loop reductions inside the top module.

## Test plan

All scenarios use NUM_FLOORS=8, DOOR_CYCLES=4, TRAVEL_CYCLES=3.

1. Reset: assert `rst` for 2 cycles with `call_req`=8'hFF → `current_floor`=0, `pending`=0, `idle`=1, `dir_up`=1, all other outputs 0.
2. Single trip: from floor 0, pulse `call_req`=8'h08 → `move_up` for 9 cycles, floor steps 1/2/3 every 3 cycles, then `door_open` for 4 cycles, then `idle` with `pending`=0.
3. SCAN order: car moving up from floor 3 toward 6; pulse `call_req` bits 5 and 1 → stops at 5, then 6, then reverses (`dir_up`→0) and stops at 1.
4. Door extension: during DOOR_OPEN at floor 2, hold `door_hold` 5 cycles, then pulse `call_req`=8'h04 → door stays open 4 cycles past the last reload, and `pending[2]` stays 0.
5. Direction tie: IDLE at floor 4 with `dir_up`=0; pulse bits 6 and 1 together → moves down to 1 first, then up to 6.
6. Reset mid-move: assert `rst` during the hop from floor 5 to 6 with `pending`=8'h80 → next cycle floor 0, `pending` 0, `idle` 1, no motion.
